// File: rtl/rpn_stack_ctrl.sv
// Operand-stack controller between the keypad/ALU front end and a single-port BRAM.
// Optional feature: define CLEAR_EN to add a synchronous stack-clear input.
module rpn_stack_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 13,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] UNARY_OP = 8'd133
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_signal,
    input  logic [DATA_W-1:0] value,
    input  logic              enter_edge,
    input  logic [DATA_W-1:0] douta,
    output logic              wea,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] op,
    output logic              result_valid,
    output logic              busy,
    output logic              empty,
    output logic              full,
    output logic              err_under,
    output logic              err_drop
`ifdef CLEAR_EN
    ,
    input  logic              clear
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W:0]   sp;
    logic [1:0]        pop_idx;
    logic [2:0]        wait_cnt;
    logic              unary;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] op_sh;

    assign busy  = (state != S_IDLE);
    assign empty = (sp == '0);
    assign full  = (sp == FULL_CNT);

    // Stack FSM: push write, three-stage pop with read-latency wait, result hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sp           <= '0;
            pop_idx      <= 2'd0;
            wait_cnt     <= 3'd0;
            unary        <= 1'b0;
            b_sh         <= '0;
            op_sh        <= '0;
            wea          <= 1'b0;
            ena          <= 1'b0;
            addra        <= '0;
            dina         <= '0;
            a            <= '0;
            b            <= '0;
            op           <= '0;
            result_valid <= 1'b0;
            err_under    <= 1'b0;
            err_drop     <= 1'b0;
`ifdef CLEAR_EN
        end else if (clear) begin
            state        <= S_IDLE;
            sp           <= '0;
            wea          <= 1'b0;
            ena          <= 1'b0;
            result_valid <= 1'b0;
            err_under    <= 1'b0;
            err_drop     <= 1'b0;
`endif
        end else begin
            wea          <= 1'b0;
            ena          <= 1'b0;
            result_valid <= 1'b0;
            err_under    <= 1'b0;
            err_drop     <= valid_signal & ((state != S_IDLE) | full);
            case (state)
                S_IDLE: begin
                    // A push wins over a simultaneous enter, which is simply lost.
                    if (valid_signal) begin
                        if (!full) begin
                            state <= S_PUSH;
                            wea   <= 1'b1;
                            ena   <= 1'b1;
                            addra <= sp[ADDR_W-1:0];
                            dina  <= value;
                        end
                    end else if (enter_edge) begin
                        if (sp < (ADDR_W+1)'(2)) begin
                            err_under <= 1'b1;
                        end else begin
                            state   <= S_ISSUE;
                            ena     <= 1'b1;
                            addra   <= ADDR_W'(sp - (ADDR_W+1)'(1));
                            pop_idx <= 2'd0;
                        end
                    end
                end
                S_PUSH: begin
                    sp    <= sp + (ADDR_W+1)'(1);
                    state <= S_IDLE;
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= 3'(RD_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        case (pop_idx)
                            2'd0: begin
                                b_sh    <= douta;
                                state   <= S_ISSUE;
                                ena     <= 1'b1;
                                addra   <= ADDR_W'(sp - (ADDR_W+1)'(2));
                                pop_idx <= 2'd1;
                            end
                            2'd1: begin
                                op_sh <= douta;
                                if (douta == UNARY_OP) begin
                                    a            <= '0;
                                    b            <= b_sh;
                                    op           <= douta;
                                    result_valid <= 1'b1;
                                    unary        <= 1'b1;
                                    state        <= S_DONE;
                                end else if (sp == (ADDR_W+1)'(2)) begin
                                    err_under <= 1'b1;
                                    state     <= S_IDLE;
                                end else begin
                                    state   <= S_ISSUE;
                                    ena     <= 1'b1;
                                    addra   <= ADDR_W'(sp - (ADDR_W+1)'(3));
                                    pop_idx <= 2'd2;
                                end
                            end
                            default: begin
                                a            <= douta;
                                b            <= b_sh;
                                op           <= op_sh;
                                result_valid <= 1'b1;
                                unary        <= 1'b0;
                                state        <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    sp    <= unary ? (sp - (ADDR_W+1)'(2)) : (sp - (ADDR_W+1)'(3));
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed scoreboard bench for rpn_stack_ctrl: a 13-bit-address instance and a 2-bit-address
// instance, each with a behavioural BRAM of read latency 2.
module tb_rpn_stack_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] value;
    logic       valid_s [2];
    logic       enter_s [2];
`ifdef CLEAR_EN
    logic       clr;
`endif

    logic        ena_w [2], wea_w [2], rv_w [2], eu_w [2], ed_w [2];
    logic        busy_w [2], empty_w [2], full_w [2];
    logic [7:0]  a_w [2], b_w [2], op_w [2], dina_w [2];
    logic [12:0] addra0;
    logic [1:0]  addra1;
    logic [7:0]  mem0 [8192];
    logic [7:0]  mem1 [4];
    logic [7:0]  pipe0 [2];
    logic [7:0]  pipe1 [2];

    rpn_stack_ctrl #(.DATA_W(8), .ADDR_W(13), .RD_LAT(2), .UNARY_OP(8'd133)) dut0 (
        .clk(clk), .rst(rst), .valid_signal(valid_s[0]), .value(value), .enter_edge(enter_s[0]),
        .douta(pipe0[1]), .wea(wea_w[0]), .ena(ena_w[0]), .addra(addra0), .dina(dina_w[0]),
        .a(a_w[0]), .b(b_w[0]), .op(op_w[0]), .result_valid(rv_w[0]), .busy(busy_w[0]),
        .empty(empty_w[0]), .full(full_w[0]), .err_under(eu_w[0]), .err_drop(ed_w[0])
`ifdef CLEAR_EN
        , .clear(clr)
`endif
    );

    rpn_stack_ctrl #(.DATA_W(8), .ADDR_W(2), .RD_LAT(2), .UNARY_OP(8'd133)) dut1 (
        .clk(clk), .rst(rst), .valid_signal(valid_s[1]), .value(value), .enter_edge(enter_s[1]),
        .douta(pipe1[1]), .wea(wea_w[1]), .ena(ena_w[1]), .addra(addra1), .dina(dina_w[1]),
        .a(a_w[1]), .b(b_w[1]), .op(op_w[1]), .result_valid(rv_w[1]), .busy(busy_w[1]),
        .empty(empty_w[1]), .full(full_w[1]), .err_under(eu_w[1]), .err_drop(ed_w[1])
`ifdef CLEAR_EN
        , .clear(clr)
`endif
    );

    // Behavioural BRAMs: read data appears two cycles after the enable cycle.
    always @(posedge clk) begin
        if (ena_w[0] && wea_w[0]) mem0[addra0] <= dina_w[0];
        pipe0[0] <= (ena_w[0] && !wea_w[0]) ? mem0[addra0] : 8'h00;
        pipe0[1] <= pipe0[0];
        if (ena_w[1] && wea_w[1]) mem1[addra1] <= dina_w[1];
        pipe1[0] <= (ena_w[1] && !wea_w[1]) ? mem1[addra1] : 8'h00;
        pipe1[1] <= pipe1[0];
    end

    typedef struct {
        int          rv;
        int          eu;
        int          ed;
        logic [31:0] ena_h;
        logic [31:0] wea_h;
        logic [31:0] busy_h;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [7:0]  din;
    } exp_t;

    exp_t exp_q [$];
    exp_t o;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] la [2];
    logic [7:0] lb [2];
    logic [7:0] lo [2];

    function automatic exp_t mk(input int rv, input int eu, input int ed,
                                input logic [31:0] ena_h, input logic [31:0] wea_h,
                                input logic [31:0] busy_h, input logic [7:0] ea,
                                input logic [7:0] eb, input logic [7:0] eop,
                                input logic [31:0] addr, input logic [7:0] din);
        exp_t e;
        e.rv = rv; e.eu = eu; e.ed = ed;
        e.ena_h = ena_h; e.wea_h = wea_h; e.busy_h = busy_h;
        e.a = ea; e.b = eb; e.op = eop; e.addr = addr; e.din = din;
        return e;
    endfunction

    function automatic logic [31:0] addr_of(input int u);
        return (u == 0) ? 32'(addra0) : 32'(addra1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observe unit u for n cycles after a request, optionally pulsing push/clear/reset at given cycles.
    task automatic run(input int u, input int n, input int drop_at, input int clr_at, input int rst_at);
        o.rv = 0; o.eu = 0; o.ed = 0;
        o.ena_h = '0; o.wea_h = '0; o.busy_h = '0;
        o.a = '0; o.b = '0; o.op = '0; o.addr = '0; o.din = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (rv_w[u] && o.rv == 0) begin
                o.rv = i; o.a = a_w[u]; o.b = b_w[u]; o.op = op_w[u];
            end
            if (eu_w[u] && o.eu == 0) o.eu = i;
            if (ed_w[u] && o.ed == 0) o.ed = i;
            if (wea_w[u] && o.wea_h == '0) begin
                o.addr = addr_of(u); o.din = dina_w[u];
            end
            if (wea_w[u])  o.wea_h[i]  = 1'b1;
            if (ena_w[u])  o.ena_h[i]  = 1'b1;
            if (busy_w[u]) o.busy_h[i] = 1'b1;
            if (i == n && o.rv == 0) begin
                o.a = a_w[u]; o.b = b_w[u]; o.op = op_w[u];
            end
            valid_s[u] = (i == drop_at);
            enter_s[u] = 1'b0;
            rst        = (i == rst_at);
`ifdef CLEAR_EN
            clr        = (i == clr_at);
`endif
        end
    endtask

    task automatic check_exp(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, ".rv_cycle"}, 32'(o.rv), 32'(e.rv));
        chk({tag, ".err_under_cycle"}, 32'(o.eu), 32'(e.eu));
        chk({tag, ".err_drop_cycle"}, 32'(o.ed), 32'(e.ed));
        chk({tag, ".ena_cycles"}, o.ena_h, e.ena_h);
        chk({tag, ".wea_cycles"}, o.wea_h, e.wea_h);
        chk({tag, ".busy_cycles"}, o.busy_h, e.busy_h);
        chk({tag, ".a_b_op"}, 32'({o.a, o.b, o.op}), 32'({e.a, e.b, e.op}));
        chk({tag, ".write"}, {o.addr[23:0], o.din}, {e.addr[23:0], e.din});
    endtask

    task automatic push(input int u, input logic [7:0] v, input int ad);
        @(negedge clk);
        valid_s[u] = 1'b1;
        value      = v;
        exp_q.push_back(mk(0, 0, 0, 32'h2, 32'h2, 32'h2, la[u], lb[u], lo[u], 32'(ad), v));
        run(u, 3, 0, 0, 0);
        check_exp("push");
    endtask

    task automatic enter(input int u, input exp_t e, input int drop_at, input int clr_at);
        @(negedge clk);
        enter_s[u] = 1'b1;
        exp_q.push_back(e);
        run(u, 14, drop_at, clr_at, 0);
        check_exp("enter");
        if (e.rv != 0) begin
            la[u] = e.a; lb[u] = e.b; lo[u] = e.op;
        end
    endtask

    task automatic check_reset(input int u);
        chk("reset.flags", 32'({empty_w[u], full_w[u], busy_w[u], ena_w[u], wea_w[u],
                                rv_w[u], eu_w[u], ed_w[u]}), 32'h80);
        chk("reset.a_b_op", 32'({a_w[u], b_w[u], op_w[u]}), 32'h0);
        chk("reset.bram", {addr_of(u)[23:0], dina_w[u]}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            la[k] = 8'd0; lb[k] = 8'd0; lo[k] = 8'd0;
        end
    endtask

    initial begin
        rst = 1'b1;
        value = 8'd0;
        for (int k = 0; k < 2; k++) begin
            valid_s[k] = 1'b0; enter_s[k] = 1'b0;
            la[k] = 8'd0; lb[k] = 8'd0; lo[k] = 8'd0;
        end
`ifdef CLEAR_EN
        clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset(0);
        check_reset(1);

        // Unary operator: single pop pair, a forced to zero.
        push(0, 8'd5, 0);
        push(0, 8'd133, 1);
        push(0, 8'd7, 2);
        enter(0, mk(7, 0, 0, 32'h12, 32'h0, 32'hFE, 8'd0, 8'd7, 8'd133, 32'h0, 8'd0), 0, 0);
        chk("unary.empty", 32'(empty_w[0]), 32'h0);

        // Binary operator: three pops, stack drained.
        do_reset();
        check_reset(0);
        push(0, 8'd12, 0);
        push(0, 8'd1, 1);
        push(0, 8'd4, 2);
        enter(0, mk(10, 0, 0, 32'h92, 32'h0, 32'h7FE, 8'd12, 8'd4, 8'd1, 32'h0, 8'd0), 0, 0);
        chk("binary.empty", 32'(empty_w[0]), 32'h1);

        // Underflow: one entry, then two entries with a binary operator.
        push(0, 8'd9, 0);
        enter(0, mk(0, 1, 0, 32'h0, 32'h0, 32'h0, 8'd12, 8'd4, 8'd1, 32'h0, 8'd0), 0, 0);
        chk("under1.empty", 32'(empty_w[0]), 32'h0);
        push(0, 8'd2, 1);
        enter(0, mk(0, 7, 0, 32'h12, 32'h0, 32'h7E, 8'd12, 8'd4, 8'd1, 32'h0, 8'd0), 0, 0);
        chk("under2.empty", 32'(empty_w[0]), 32'h0);

        // Push and enter in the same cycle: only the push happens.
        @(negedge clk);
        valid_s[0] = 1'b1;
        enter_s[0] = 1'b1;
        value      = 8'd11;
        exp_q.push_back(mk(0, 0, 0, 32'h2, 32'h2, 32'h2, 8'd12, 8'd4, 8'd1, 32'h2, 8'd11));
        run(0, 14, 0, 0, 0);
        check_exp("push_and_enter");
        enter(0, mk(10, 0, 0, 32'h92, 32'h0, 32'h7FE, 8'd9, 8'd11, 8'd2, 32'h0, 8'd0), 0, 0);
        chk("after_both.empty", 32'(empty_w[0]), 32'h1);

        // Four-entry stack: fill, refused push, push refused while popping.
        push(1, 8'd21, 0);
        push(1, 8'd22, 1);
        push(1, 8'd23, 2);
        push(1, 8'd24, 3);
        chk("fill.full", 32'(full_w[1]), 32'h1);
        @(negedge clk);
        valid_s[1] = 1'b1;
        value      = 8'd25;
        exp_q.push_back(mk(0, 0, 1, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 32'h0, 8'd0));
        run(1, 3, 0, 0, 0);
        check_exp("push_when_full");
        chk("drop.full", 32'(full_w[1]), 32'h1);
        enter(1, mk(10, 0, 4, 32'h92, 32'h0, 32'h7FE, 8'd22, 8'd24, 8'd23, 32'h0, 8'd0), 3, 0);
        chk("pop.full", 32'(full_w[1]), 32'h0);
        chk("pop.empty", 32'(empty_w[1]), 32'h0);

`ifdef CLEAR_EN
        // Clear during a pop sequence aborts it without a result.
        push(0, 8'd1, 0);
        push(0, 8'd2, 1);
        push(0, 8'd3, 2);
        enter(0, mk(0, 0, 0, 32'h2, 32'h0, 32'hE, 8'd9, 8'd11, 8'd2, 32'h0, 8'd0), 0, 3);
        chk("clear.empty", 32'(empty_w[0]), 32'h1);
`endif

        // Reset in the middle of a push returns every output to its reset value.
        @(negedge clk);
        valid_s[0] = 1'b1;
        value      = 8'd77;
        exp_q.push_back(mk(0, 0, 0, 32'h2, 32'h2, 32'h2, 8'd0, 8'd0, 8'd0, 32'h0, 8'd77));
        run(0, 3, 0, 0, 1);
        check_exp("reset_mid_push");
        check_reset(0);
        check_reset(1);

        chk("scoreboard.drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
